// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and oversampling rate.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx.sv
// UART serial transmitter driven by a 16x oversample tick; start, DBIT data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_t       state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic            p_reg, p_next;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      p_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
      p_reg     <= p_next;
`endif
    end
  end

  // tx_next carries the line level of the state being entered, so tx changes on the same edge as state.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    p_next     = p_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          b_next     = din;
          tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
          p_next     = ^din;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == S_BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next  = '0;
            b_next  = b_reg >> 1;
            tx_next = b_next[0];
            if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
              tx_next    = p_reg;
`else
              state_next = STOP;
              tx_next    = 1'b1;
`endif
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_reg == S_BIT_LAST) begin
            state_next = STOP;
            s_next     = '0;
            tx_next    = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx           = tx_reg;
  assign tx_done_tick = done_reg;
  assign tx_busy      = (state_reg != IDLE);

endmodule
